// File: rtl/spin_pkg.sv
// rtl/spin_pkg.sv - shared types and helpers for the spinner/dial input stage
package spin_pkg;

  // Accumulator width is the visible angle plus the fractional bits below it.
  function automatic int acc_width(input int out_w, input int frac_w);
    return out_w + frac_w;
  endfunction

  // HPS spinner deltas are 8-bit two's complement; widen for modular adds.
  function automatic logic [31:0] sext_delta(input logic [7:0] d);
    return {{24{d[7]}}, d};
  endfunction

  // One analog spinner event: valid for the cycle the toggle bit flipped.
  typedef struct packed {
    logic       valid;
    logic [7:0] delta;
  } spin_evt_t;

  // Direction of the digital controls on a frame tick.
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_t;

endpackage

// File: rtl/spin_chan.sv
// rtl/spin_chan.sv - per-spinner arming and toggle-to-event detection
module spin_chan
  import spin_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] spin_in,
  output spin_evt_t  evt
);

  logic tog_q;
  logic armed;

  // Track the toggle bit every cycle; the first post-reset cycle only arms.
  always_ff @(posedge clk) begin
    tog_q <= spin_in[8];
    if (reset) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // An event is a toggle-bit change seen once armed; delta rides along.
  always_comb begin
    evt       = '0;
    evt.valid = armed & (spin_in[8] != tog_q);
    evt.delta = spin_in[7:0];
  end

endmodule

// File: rtl/spin_dial.sv
// rtl/spin_dial.sv - merges spinners and digital controls into one wrapping dial angle
module spin_dial
  import spin_pkg::*;
#(
  parameter int OUT_W       = 4,
  parameter int FRAC_W      = 4,
  parameter int BASE_RATE   = 2,
  parameter int ACCEL_MAX   = 14,
  parameter int ACCEL_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             plus,
  input  logic             minus,
  input  logic             fast,
  input  logic             strobe,
  input  logic [8:0]       spin_in0,
  input  logic [8:0]       spin_in1,
  output logic [OUT_W-1:0] spin_out,
  output logic             src_sel,
  output logic             moved
);

  localparam int ACC_W  = acc_width(OUT_W, FRAC_W);
  localparam int HOLD_W = $clog2(ACCEL_MAX + 1);

  spin_evt_t evt0;
  spin_evt_t evt1;

  logic [ACC_W-1:0]  acc,   acc_nx;
  logic [HOLD_W-1:0] hold,  hold_nx;
  dir_t              dir_q, dir_nx;
  logic              strobe_q;
  logic              src_nx;
  logic              moved_nx;

  dir_t              dir;
  logic              tick;
  logic [ACC_W-1:0]  rate;
  logic [ACC_W-1:0]  step;
  logic [ACC_W-1:0]  d0;
  logic [ACC_W-1:0]  d1;
  logic [ACC_W-1:0]  sum;

  spin_chan u_chan0 (
    .clk     (clk),
    .reset   (reset),
    .spin_in (spin_in0),
    .evt     (evt0)
  );

  spin_chan u_chan1 (
    .clk     (clk),
    .reset   (reset),
    .spin_in (spin_in1),
    .evt     (evt1)
  );

  // Sum digital step and both analog deltas into a single modular update.
  always_comb begin
    tick     = strobe & ~strobe_q;
    dir      = DIR_NONE;
    rate     = ACC_W'(BASE_RATE) + ACC_W'(hold >> ACCEL_SHIFT);
    step     = '0;
    d0       = '0;
    d1       = '0;
    hold_nx  = hold;
    dir_nx   = dir_q;
    src_nx   = src_sel;

    if (plus && !minus) begin
      dir = DIR_CW;
    end else if (minus && !plus) begin
      dir = DIR_CCW;
    end

    if (fast) begin
      rate = rate << 1;
    end

    // Rate uses the hold value from before this tick; release or reversal clears it.
    if (tick) begin
      dir_nx = dir;
      if (dir == DIR_CW) begin
        step = rate;
      end else if (dir == DIR_CCW) begin
        step = -rate;
      end
      if (dir == DIR_NONE) begin
        hold_nx = '0;
      end else if (dir_q != DIR_NONE && dir != dir_q) begin
        hold_nx = '0;
      end else if (hold < HOLD_W'(ACCEL_MAX)) begin
        hold_nx = hold + 1'b1;
      end
    end

    if (evt0.valid) begin
      d0 = ACC_W'(sext_delta(evt0.delta));
    end
    if (evt1.valid) begin
      d1 = ACC_W'(sext_delta(evt1.delta));
    end

    if (evt1.valid && !evt0.valid) begin
      src_nx = 1'b1;
    end else if (evt0.valid && !evt1.valid) begin
      src_nx = 1'b0;
    end

    sum      = step + d0 + d1;
    acc_nx   = acc + sum;
    moved_nx = (sum != '0);
  end

  // Register accumulator, acceleration state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      hold     <= '0;
      dir_q    <= DIR_NONE;
      strobe_q <= 1'b0;
      src_sel  <= 1'b0;
      moved    <= 1'b0;
    end else begin
      acc      <= acc_nx;
      hold     <= hold_nx;
      dir_q    <= dir_nx;
      strobe_q <= strobe;
      src_sel  <= src_nx;
      moved    <= moved_nx;
    end
  end

  assign spin_out = acc[ACC_W-1:FRAC_W];

endmodule

// File: tb/tb_spin_dial.sv
// tb/tb_spin_dial.sv - scoreboard bench for spin_dial with directed vectors
module tb_spin_dial;

  logic       clk = 1'b0;
  logic       reset;
  logic       plus, minus, fast, strobe;
  logic [8:0] spin_in0, spin_in1;
  logic [3:0] spin_out;
  logic       src_sel;
  logic       moved;

  typedef struct {
    logic [7:0] acc;
    logic       src;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   moved_cnt = 0;

  spin_dial dut (
    .clk      (clk),
    .reset    (reset),
    .plus     (plus),
    .minus    (minus),
    .fast     (fast),
    .strobe   (strobe),
    .spin_in0 (spin_in0),
    .spin_in1 (spin_in1),
    .spin_out (spin_out),
    .src_sel  (src_sel),
    .moved    (moved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every moved pulse must match the next expected update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (moved === 1'b1) begin
        moved_cnt++;
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_moved: got acc 0x%0h expected no movement", dut.acc);
        end else begin
          e = sbq.pop_front();
          chk("sb_acc", 32'(dut.acc), 32'(e.acc));
          chk("sb_spin_out", 32'(spin_out), 32'(e.acc[7:4]));
          chk("sb_src_sel", 32'(src_sel), 32'(e.src));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic s);
    exp_t e;
    e.acc = a;
    e.src = s;
    sbq.push_back(e);
  endtask

  task automatic frame(input logic p, input logic m, input logic f);
    plus   = p;
    minus  = m;
    fast   = f;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    fast   = 1'b0;
    tick();
  endtask

  int          rates [16] = '{2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 8, 8, 9, 9};
  logic [7:0]  exp_acc;
  int          mc;
  int          plus_rates [6] = '{2, 2, 3, 3, 4, 4};

  initial begin
    reset = 1'b1; plus = 0; minus = 0; fast = 0; strobe = 0;
    spin_in0 = 9'h100; spin_in1 = 9'h000;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_spin_out", 32'(spin_out), 0);
    chk("reset_moved", 32'(moved), 0);
    chk("reset_src", 32'(src_sel), 0);
    repeat (10) tick();
    chk("no_spurious_moved", moved_cnt, 0);
    chk("idle_acc", 32'(dut.acc), 0);

    // digital acceleration: rates 2,2,3,3,4,4
    exp_acc = 8'h00;
    for (int i = 0; i < 6; i++) begin
      exp_acc = exp_acc + 8'(plus_rates[i]);
      push(exp_acc, 1'b0);
      frame(1, 0, 0);
    end
    chk("accel_spin_out", 32'(spin_out), 1);
    chk("accel_acc", 32'(dut.acc), 32'h12);
    chk("accel_hold", 32'(dut.hold), 6);
    frame(0, 0, 0);
    chk("release_hold", 32'(dut.hold), 0);

    // analog back to zero, then spinner 1 delta -3
    push(8'h00, 1'b0);
    spin_in0 = {1'b0, 8'hEE}; tick();
    push(8'hFD, 1'b1);
    spin_in1 = {1'b1, 8'hFD}; tick();
    tick();

    // simultaneous: minus+fast step -4, two analog +4 -> net +4
    push(8'h01, 1'b1);
    minus = 1; fast = 1; strobe = 1;
    spin_in0 = {1'b1, 8'h04}; spin_in1 = {1'b0, 8'h04};
    tick();
    strobe = 0; minus = 0; fast = 0;
    tick();
    chk("simul_hold", 32'(dut.hold), 1);
    frame(0, 0, 0);

    // wrap-around 0x00 - 1
    push(8'h00, 1'b0);
    spin_in0 = {1'b0, 8'hFF}; tick();
    push(8'hFF, 1'b1);
    spin_in1 = {1'b1, 8'hFF}; tick();
    tick();

    // opposite analog deltas cancel: no movement, source unchanged
    mc = moved_cnt;
    spin_in0 = {1'b1, 8'h03}; spin_in1 = {1'b0, 8'hFD};
    tick(); tick();
    chk("net_zero_moved", moved_cnt, mc);
    chk("net_zero_src", 32'(src_sel), 1);
    chk("net_zero_acc", 32'(dut.acc), 32'hFF);

    // accelerate then both pressed clears hold
    push(8'h01, 1'b1); frame(1, 0, 0);
    push(8'h03, 1'b1); frame(1, 0, 0);
    push(8'h06, 1'b1); frame(1, 0, 0);
    chk("pre_both_hold", 32'(dut.hold), 3);
    mc = moved_cnt;
    for (int i = 0; i < 3; i++) frame(1, 1, 0);
    chk("both_hold", 32'(dut.hold), 0);
    chk("both_moved", moved_cnt, mc);
    push(8'h08, 1'b1); frame(1, 0, 0);

    // reversal uses old hold for its rate, then clears it
    push(8'h0A, 1'b1); frame(1, 0, 0);
    push(8'h0D, 1'b1); frame(1, 0, 0);
    push(8'h10, 1'b1); frame(1, 0, 0);
    push(8'h0C, 1'b1); frame(0, 1, 0);
    chk("reversal_hold", 32'(dut.hold), 0);
    push(8'h0A, 1'b1); frame(0, 1, 0);
    frame(0, 0, 0);

    // hold saturates at ACCEL_MAX
    exp_acc = 8'h0A;
    for (int i = 0; i < 16; i++) begin
      exp_acc = exp_acc + 8'(rates[i]);
      push(exp_acc, 1'b1);
      frame(1, 0, 0);
    end
    chk("sat_hold", 32'(dut.hold), 14);
    chk("sat_acc", 32'(dut.acc), 32'h62);
    frame(0, 0, 0);

    // set up acc=0x37 with hold=5
    push(8'h29, 1'b0);
    spin_in0 = {1'b0, 8'hC7}; tick();
    push(8'h2B, 1'b0); frame(1, 0, 0);
    push(8'h2D, 1'b0); frame(1, 0, 0);
    push(8'h30, 1'b0); frame(1, 0, 0);
    push(8'h33, 1'b0); frame(1, 0, 0);
    push(8'h37, 1'b0); frame(1, 0, 0);
    chk("pre_reset_hold", 32'(dut.hold), 5);
    plus = 0;
    // zero-delta event on spinner 1 selects the source without movement
    mc = moved_cnt;
    spin_in1 = {1'b1, 8'h00}; tick();
    chk("zero_delta_src", 32'(src_sel), 1);
    chk("zero_delta_moved", moved_cnt, mc);

    // reset with a toggle pending
    reset = 1'b1;
    spin_in0 = {1'b1, 8'h11};
    tick();
    chk("midreset_acc", 32'(dut.acc), 0);
    chk("midreset_hold", 32'(dut.hold), 0);
    chk("midreset_spin_out", 32'(spin_out), 0);
    chk("midreset_src", 32'(src_sel), 0);
    chk("midreset_moved", 32'(moved), 0);
    reset = 1'b0;
    mc = moved_cnt;
    repeat (6) tick();
    chk("post_reset_moved", moved_cnt, mc);
    chk("post_reset_acc", 32'(dut.acc), 0);
    push(8'h05, 1'b0);
    spin_in0 = {1'b0, 8'h05}; tick();

    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
